// File: rtl/addseq_pkg.sv
// Shared constants for the adder sequencer: state encodings, result beat
// indices, z-word flag positions and group sizes.
package addseq_pkg;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_e;

    localparam logic [2:0] IDX_V = 3'd0;
    localparam logic [2:0] IDX_W = 3'd1;
    localparam logic [2:0] IDX_X = 3'd2;
    localparam logic [2:0] IDX_Y = 3'd3;
    localparam logic [2:0] IDX_Z = 3'd4;

    localparam int FLAG_C0   = 0;
    localparam int FLAG_C1   = 1;
    localparam int FLAG_C2   = 2;
    localparam int FLAG_ZERO = 3;

    localparam int NUM_OPERANDS = 4;
    localparam int NUM_RESULTS  = 5;
    localparam int NUM_STEPS    = 3;

endpackage

// File: rtl/adder_sequencer_if.sv
// Operand and result streams of the adder sequencer.
// Handshake: a beat transfers on a rising clk edge where valid && ready are
// both high; the source holds data stable while valid is high and ready is
// low, and neither side derives its valid/ready from the other's signal.
interface adder_sequencer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       out_idx;

    // Producer/consumer side (drives operands, accepts results).
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_idx
    );

    // Sequencer side.
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_idx
    );
endinterface

// File: rtl/addseq_add.sv
// Shared combinational WIDTH-bit adder.
// Macro ADDSEQ_SAT_EN: when defined the sum saturates to all-ones on carry;
// carry_out always reports the raw carry either way.
module addseq_add #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);
    logic [WIDTH:0] raw;

    assign raw       = {1'b0, op_a} + {1'b0, op_b};
    assign carry_out = raw[WIDTH];

`ifdef ADDSEQ_SAT_EN
    assign sum = raw[WIDTH] ? {WIDTH{1'b1}} : raw[WIDTH-1:0];
`else
    assign sum = raw[WIDTH-1:0];
`endif

endmodule

// File: rtl/adder_sequencer.sv
// Adder sequencer: collects a,b,c,d serially, reduces them with one shared
// adder over three cycles, then emits v,w,x,y,z serially.
// Macro ADDSEQ_SAT_EN (in addseq_add) selects saturating adder steps.
module adder_sequencer
    import addseq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    adder_sequencer_if.slave    bus,
    output logic                busy,
    output logic [1:0]          state_dbg
);
    localparam logic [1:0] LOAD    = ST_LOAD;
    localparam logic [1:0] COMPUTE = ST_COMPUTE;
    localparam logic [1:0] OUTPUT  = ST_OUTPUT;

    logic [1:0]       state;
    logic [1:0]       op_cnt;
    logic [1:0]       step;
    logic [2:0]       idx;
    logic [WIDTH-1:0] ops [NUM_OPERANDS];
    logic [WIDTH-1:0] res [NUM_RESULTS];
    logic             c0;
    logic             c1;

    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_carry;
    logic [WIDTH-1:0] z_word;

    // Handshake outputs depend only on state, never on the peer.
    assign bus.in_ready  = (state == LOAD);
    assign bus.out_valid = (state == OUTPUT);
    assign bus.out_data  = (state == OUTPUT) ? res[idx] : '0;
    assign bus.out_idx   = idx;
    assign busy          = (state != LOAD);
    assign state_dbg     = state;

    // Steer the operand pair for the current compute step into the adder.
    always_comb begin
        add_a = ops[0];
        add_b = ops[1];
        case (step)
            2'd1: begin
                add_a = ops[2];
                add_b = ops[3];
            end
            2'd2: begin
                add_a = res[IDX_V];
                add_b = res[IDX_W];
            end
            default: begin
                add_a = ops[0];
                add_b = ops[1];
            end
        endcase
    end

    addseq_add #(.WIDTH(WIDTH)) u_add (
        .op_a      (add_a),
        .op_b      (add_b),
        .sum       (add_sum),
        .carry_out (add_carry)
    );

    // Flag word built during the final step, using that step's carry and sum.
    always_comb begin
        z_word            = '0;
        z_word[FLAG_C0]   = c0;
        z_word[FLAG_C1]   = c1;
        z_word[FLAG_C2]   = add_carry;
        z_word[FLAG_ZERO] = (add_sum == '0);
    end

    // Sequencer FSM: load operands, run three adder steps, stream results.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= LOAD;
            op_cnt <= '0;
            step   <= '0;
            idx    <= '0;
            c0     <= 1'b0;
            c1     <= 1'b0;
            for (int i = 0; i < NUM_OPERANDS; i++) ops[i] <= '0;
            for (int i = 0; i < NUM_RESULTS; i++)  res[i] <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (bus.in_valid) begin
                        ops[op_cnt] <= bus.in_data;
                        op_cnt      <= op_cnt + 2'd1;
                        if (op_cnt == 2'(NUM_OPERANDS - 1)) begin
                            state <= COMPUTE;
                            step  <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    case (step)
                        2'd0: begin
                            res[IDX_V] <= add_sum;
                            c0         <= add_carry;
                            step       <= 2'd1;
                        end
                        2'd1: begin
                            res[IDX_W] <= add_sum;
                            c1         <= add_carry;
                            step       <= 2'd2;
                        end
                        default: begin
                            res[IDX_X] <= add_sum;
                            res[IDX_Y] <= WIDTH'(c0) + WIDTH'(c1) + WIDTH'(add_carry);
                            res[IDX_Z] <= z_word;
                            step       <= '0;
                            idx        <= IDX_V;
                            state      <= OUTPUT;
                        end
                    endcase
                end
                OUTPUT: begin
                    if (bus.out_ready) begin
                        if (idx == IDX_Z) begin
                            idx    <= '0;
                            op_cnt <= '0;
                            state  <= LOAD;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_sequencer.sv
// Self-checking bench for adder_sequencer (covers both ADDSEQ_SAT_EN builds).
module tb_adder_sequencer;
    import addseq_pkg::*;

    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    adder_sequencer_if #(.WIDTH(W)) bus ();
    logic       busy;
    logic [1:0] state_dbg;

    adder_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int check_cnt = 0;
    int pass_cnt  = 0;
    int cyc       = 0;
    int in_cnt    = 0;
    int last_d_cyc = 0;
    logic prev_ov = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [2:0]   exp_idx_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: exclusivity, latency, and output beats against the queue.
    always @(negedge clk) begin
        if (!reset) begin
            check("excl", 32'(bus.in_ready & bus.out_valid), 0);
            if (bus.in_valid && bus.in_ready) begin
                if (in_cnt == 3) last_d_cyc = cyc;
                in_cnt = (in_cnt + 1) % 4;
            end
            if (bus.out_valid && !prev_ov) check("latency", cyc - last_d_cyc, 4);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", exp_q.size(), 1);
                end else begin
                    check("out_data", bus.out_data, exp_q.pop_front());
                    check("out_idx", bus.out_idx, exp_idx_q.pop_front());
                end
            end
        end
        prev_ov = bus.out_valid;
    end

    // ---------------- model ----------------
    function automatic logic [4*W-1:0] pack4(input logic [W-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    function automatic logic [5*W-1:0] pack5(input logic [W-1:0] v, w, x, y, z);
        return {z, y, x, w, v};
    endfunction

    function automatic logic [5*W-1:0] model(input logic [W-1:0] a, b, c, d);
        logic [W:0]   s0, s1, s2;
        logic [W-1:0] v, w, x, y, z;
        s0 = {1'b0, a} + {1'b0, b};
        s1 = {1'b0, c} + {1'b0, d};
        v = s0[W-1:0];
        w = s1[W-1:0];
`ifdef ADDSEQ_SAT_EN
        if (s0[W]) v = '1;
        if (s1[W]) w = '1;
`endif
        s2 = {1'b0, v} + {1'b0, w};
        x = s2[W-1:0];
`ifdef ADDSEQ_SAT_EN
        if (s2[W]) x = '1;
`endif
        y = W'(s0[W]) + W'(s1[W]) + W'(s2[W]);
        z = '0;
        z[0] = s0[W];
        z[1] = s1[W];
        z[2] = s2[W];
        z[3] = (x == '0);
        return pack5(v, w, x, y, z);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0;
        exp_q.delete();
        exp_idx_q.delete();
        tick();
        reset = 1'b0;
        in_cnt = 0;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input int gap);
        logic acc;
        acc = 1'b0;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            if (acc) break;
        end
        check("in_accept", 32'(acc), 1);
        bus.in_valid = 1'b0;
        bus.in_data  = W'($urandom_range(0, 255));
        repeat (gap) tick();
    endtask

    task automatic send_group(input logic [4*W-1:0] ops, input logic [5*W-1:0] exp,
                              input int gap_lo, input int gap_hi);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(exp[i*W +: W]);
            exp_idx_q.push_back(3'(i));
        end
        for (int i = 0; i < 4; i++) send_beat(ops[i*W +: W], int'($urandom_range(gap_hi, gap_lo)));
    endtask

    task automatic wait_drain(input logic rand_ready);
        for (int n = 0; n < 400 && exp_q.size() != 0; n++) begin
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check("drain", exp_q.size(), 0);
    endtask

    task automatic wait_idx(input logic [2:0] target);
        logic seen;
        seen = 1'b0;
        bus.out_ready = 1'b1;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (bus.out_valid && bus.out_idx == target) begin
                seen = 1'b1;
                break;
            end
        end
        bus.out_ready = 1'b0;
        check("reach_idx", 32'(seen), 1);
    endtask

    task automatic send_random_group();
        logic [W-1:0] a, b, c, d;
        a = W'($urandom_range(0, 255));
        b = W'($urandom_range(0, 255));
        c = W'($urandom_range(0, 255));
        d = W'($urandom_range(0, 255));
        send_group(pack4(a, b, c, d), model(a, b, c, d), 0, 2);
        wait_drain(1'b1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_out_idx", 32'(bus.out_idx), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_state", 32'(state_dbg), 32'(ST_LOAD));
        tick();

        // Basic group, continuous handshakes
        send_group(pack4(10, 20, 30, 40), pack5(30, 70, 100, 0, 0), 0, 0);
        wait_drain(1'b0);

        // Overflow
`ifdef ADDSEQ_SAT_EN
        send_group(pack4(200, 100, 255, 1), pack5(255, 255, 255, 3, 7), 0, 0);
`else
        send_group(pack4(200, 100, 255, 1), pack5(44, 0, 44, 2, 3), 0, 0);
`endif
        wait_drain(1'b0);

        // Zero flag, then all-128 group
        send_group(pack4(0, 0, 0, 0), pack5(0, 0, 0, 0, 8), 0, 0);
        wait_drain(1'b0);
`ifdef ADDSEQ_SAT_EN
        send_group(pack4(128, 128, 128, 128), pack5(255, 255, 255, 3, 7), 0, 0);
`else
        send_group(pack4(128, 128, 128, 128), pack5(0, 0, 0, 2, 11), 0, 0);
`endif
        wait_drain(1'b0);

        // Input gaps and output backpressure held at idx 2
        send_group(pack4(7, 9, 11, 13), pack5(16, 24, 40, 0, 0), 1, 1);
        wait_idx(IDX_X);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_data", 32'(bus.out_data), 40);
            check("hold_idx", 32'(bus.out_idx), 2);
            check("hold_valid", 32'(bus.out_valid), 1);
            check("hold_in_ready", 32'(bus.in_ready), 0);
            check("hold_busy", 32'(busy), 1);
        end
        tick();
        wait_drain(1'b0);

        // Reset after two operands
        send_beat(1, 0);
        send_beat(2, 0);
        do_reset();
        @(negedge clk);
        check("rst2_in_ready", 32'(bus.in_ready), 1);
        check("rst2_out_valid", 32'(bus.out_valid), 0);
        check("rst2_busy", 32'(busy), 0);
        tick();
        send_group(pack4(1, 2, 3, 4), pack5(3, 7, 10, 0, 0), 0, 0);
        wait_drain(1'b0);

        // Reset during output at idx 3
        send_group(pack4(5, 6, 7, 8), pack5(11, 15, 26, 0, 0), 0, 0);
        wait_idx(IDX_Y);
        do_reset();
        @(negedge clk);
        check("rst3_out_valid", 32'(bus.out_valid), 0);
        check("rst3_out_idx", 32'(bus.out_idx), 0);
        check("rst3_out_data", 32'(bus.out_data), 0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            check("rst3_quiet", 32'(bus.out_valid), 0);
        end
        tick();

        // Random groups with random gaps and backpressure
        for (int g = 0; g < 6; g++) send_random_group();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
